// File: rtl/aes_lite_core.sv
// aes_lite_core: byte-serial XOR/rotate block cipher core.
// A block and its key are shifted in MSB-first, one byte per accepted cycle.
// ROUNDS iterative rounds then run in the latched direction. The result is
// registered together with a one-cycle out_valid strobe. That strobe is high
// for the single DONE cycle, and out_data holds its value until the next strobe.
module aes_lite_core #(
    parameter int NBYTES = 2,
    parameter int ROUNDS = 4
) (
    input  logic                  in_clk,
    input  logic                  in_restart_n,
    input  logic                  in_valid,
    input  logic                  in_enable_encode,
    input  logic [7:0]            in_d_in,
    input  logic [7:0]            in_key_in,
    output logic                  out_ready,
    output logic                  out_busy,
    output logic                  out_valid,
    output logic [8*NBYTES-1:0]   out_data
);
    localparam int W  = 8 * NBYTES;
    localparam int RW = $clog2(ROUNDS + 1);
    localparam int CW = $clog2(NBYTES + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    state_t          r_state;
    logic            r_encode;
    logic [W-1:0]    r_data;
    logic [W-1:0]    r_key;
    logic [W-1:0]    r_out_data;
    logic            r_out_valid;
    logic [CW-1:0]   r_cnt;
    logic [RW-1:0]   r_round;

    logic [W-1:0]    w_data_shift;
    logic [W-1:0]    w_key_shift;
    logic [W-1:0]    w_key_rot [NBYTES];
    logic [RW-1:0]   w_round_idx;
    logic [31:0]     w_rot_sel;
    logic [W-1:0]    w_round_key;
    logic [W-1:0]    w_mix;
    logic [W-1:0]    w_round_out;

    // New byte enters at the bottom; the oldest byte falls off the top.
    assign w_data_shift = W'({r_data, in_d_in});
    assign w_key_shift  = W'({r_key, in_key_in});

    // Every possible byte-granular left rotation of the key, precomputed.
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_key_rot
        assign w_key_rot[gi] = W'({r_key, r_key} >> (W - 8 * gi));
    end

    // Pick the round index, its key rotation, and fold the index into the key.
    always_comb begin
        w_round_idx = r_encode ? r_round : (RW'(ROUNDS - 1) - r_round);
        w_rot_sel   = 32'(w_round_idx) % 32'(NBYTES);
        w_round_key = w_key_rot[0];
        for (int j = 1; j < NBYTES; j++) begin
            if (w_rot_sel == 32'(j)) begin
                w_round_key = w_key_rot[j];
            end
        end
        w_round_key = w_round_key ^ W'(w_round_idx);
    end

    // One round: encode is rotl1(s ^ k), decode undoes it as rotr1(s) ^ k.
    always_comb begin
        w_mix       = r_data ^ w_round_key;
        w_round_out = {w_mix[W-2:0], w_mix[W-1]};
        if (!r_encode) begin
            w_round_out = {r_data[0], r_data[W-1:1]} ^ w_round_key;
        end
    end

    // Control FSM plus datapath registers, including the registered result.
    always_ff @(posedge in_clk or negedge in_restart_n) begin
        if (!in_restart_n) begin
            r_state     <= S_IDLE;
            r_encode    <= 1'b0;
            r_data      <= '0;
            r_key       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
            r_round     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_data   <= w_data_shift;
                        r_key    <= w_key_shift;
                        r_encode <= in_enable_encode;
                        r_cnt    <= CW'(1);
                        r_round  <= '0;
                        r_state  <= (NBYTES == 1) ? S_RUN : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        r_data <= w_data_shift;
                        r_key  <= w_key_shift;
                        r_cnt  <= r_cnt + 1'b1;
                        if (r_cnt == CW'(NBYTES - 1)) begin
                            r_round <= '0;
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_data <= w_round_out;
                    if (r_round == RW'(ROUNDS - 1)) begin
                        r_out_data  <= w_round_out;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_round <= r_round + 1'b1;
                    end
                end
                S_DONE: begin
                    // Drop the block and key so nothing carries into the next block.
                    r_out_valid <= 1'b0;
                    r_data      <= '0;
                    r_key       <= '0;
                    r_cnt       <= '0;
                    r_round     <= '0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign out_ready = (r_state == S_IDLE) || (r_state == S_LOAD);
    assign out_busy  = (r_state != S_IDLE);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_aes_lite_core.sv
// Bench for aes_lite_core: hand-computed vectors on an NBYTES=2/ROUNDS=2 core
// plus encode/decode round trips on three further parameter sets.
module tb_aes_lite_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic vchk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Rotate the low w bits of x left by n (mod w).
    function automatic logic [31:0] ref_rotl(input logic [31:0] x, input int n, input int w);
        logic [63:0] v;
        logic [63:0] m;
        int s;
        m = (64'd1 << w) - 64'd1;
        v = {32'd0, x} & m;
        s = n % w;
        if (s != 0) v = ((v << s) | (v >> (w - s))) & m;
        return v[31:0];
    endfunction

    // Cipher written straight from the round equations.
    function automatic logic [31:0] ref_cipher(input logic [31:0] x, input logic [31:0] k,
                                               input int nb, input int rounds, input bit enc);
        int w;
        logic [31:0] m;
        logic [31:0] s;
        logic [31:0] kr;
        w = 8 * nb;
        m = 32'((64'd1 << w) - 64'd1);
        s = x & m;
        if (enc) begin
            for (int r = 0; r < rounds; r++) begin
                kr = (ref_rotl(k, 8 * r, w) ^ 32'(r)) & m;
                s  = ref_rotl(s ^ kr, 1, w);
            end
        end else begin
            for (int r = rounds - 1; r >= 0; r--) begin
                kr = (ref_rotl(k, 8 * r, w) ^ 32'(r)) & m;
                s  = ref_rotl(s, w - 1, w) ^ kr;
            end
        end
        return s;
    endfunction

    // ---------------- directed-vector core (NBYTES=2, ROUNDS=2) ----------------
    logic        v_rst_n;
    logic        v_valid;
    logic        v_enc;
    logic [7:0]  v_d;
    logic [7:0]  v_k;
    logic        v_ready;
    logic        v_busy;
    logic        v_ovalid;
    logic [15:0] v_odata;

    aes_lite_core #(.NBYTES(2), .ROUNDS(2)) u_vec (
        .in_clk           (clk),
        .in_restart_n     (v_rst_n),
        .in_valid         (v_valid),
        .in_enable_encode (v_enc),
        .in_d_in          (v_d),
        .in_key_in        (v_k),
        .out_ready        (v_ready),
        .out_busy         (v_busy),
        .out_valid        (v_ovalid),
        .out_data         (v_odata)
    );

    // Load one block starting at a negedge in IDLE, then check the strobe window.
    // c counts negedges after the last-byte edge: RUN at c=0,1, DONE at c=2, IDLE at c=3.
    task automatic v_block(input logic [15:0] x, input logic [15:0] kk, input bit e,
                           input bit gapped, input logic [15:0] req, input string tag);
        for (int i = 1; i >= 0; i--) begin
            if (gapped && i == 0) begin
                v_valid = 1'b0;
                v_d     = 8'hEE;
                v_k     = 8'hDD;
                @(negedge clk);
                @(negedge clk);
            end
            v_valid = 1'b1;
            v_enc   = (gapped && i == 0) ? ~e : e;
            v_d     = x[8*i +: 8];
            v_k     = kk[8*i +: 8];
            @(negedge clk);
        end
        v_valid = gapped;
        v_d     = 8'h5A;
        v_k     = 8'hC3;
        for (int c = 0; c <= 3; c++) begin
            vchk({tag, "_valid"}, 32'(v_ovalid), 32'(c == 2));
            vchk({tag, "_ready"}, 32'(v_ready), 32'(c == 3));
            vchk({tag, "_busy"}, 32'(v_busy), 32'(c < 3));
            if (c >= 2) vchk({tag, "_data"}, 32'(v_odata), 32'(req));
            if (c < 3) @(negedge clk);
        end
        v_valid = 1'b0;
    endtask

    // ---------------- round-trip cores ----------------
    for (genvar gi = 0; gi < 3; gi++) begin : g_rt
        localparam int NB    = (gi == 0) ? 2 : ((gi == 1) ? 1 : 4);
        localparam int RN    = (gi == 0) ? 4 : ((gi == 1) ? 7 : 1);
        localparam int W     = 8 * NB;
        localparam int NPAIR = 1000;

        logic         rst_n;
        logic         valid;
        logic         enc;
        logic [7:0]   d;
        logic [7:0]   k;
        logic         ready;
        logic         busy;
        logic         ovalid;
        logic [W-1:0] odata;
        logic [W-1:0] last_data;
        logic [W-1:0] exp_q [$];
        int           exp_c [$];
        bit           done = 1'b0;

        aes_lite_core #(.NBYTES(NB), .ROUNDS(RN)) u_dut (
            .in_clk           (clk),
            .in_restart_n     (rst_n),
            .in_valid         (valid),
            .in_enable_encode (enc),
            .in_d_in          (d),
            .in_key_in        (k),
            .out_ready        (ready),
            .out_busy         (busy),
            .out_valid        (ovalid),
            .out_data         (odata)
        );

        // Feed one block with random gaps and a scrambled mode after the first byte.
        task automatic send(input logic [W-1:0] x, input logic [W-1:0] kk, input bit e,
                            input logic [W-1:0] req);
            for (int i = NB - 1; i >= 0; i--) begin
                if ($urandom_range(0, 3) == 0) begin
                    valid = 1'b0;
                    d     = 8'($urandom);
                    k     = 8'($urandom);
                    @(negedge clk);
                end
                valid = 1'b1;
                enc   = (i == NB - 1) ? e : 1'($urandom);
                d     = x[8*i +: 8];
                k     = kk[8*i +: 8];
                @(negedge clk);
            end
            valid = 1'b0;
            exp_q.push_back(req);
            exp_c.push_back(cyc + RN);
            repeat (RN + 1) @(negedge clk);
        endtask

        initial begin
            logic [W-1:0] x;
            logic [W-1:0] kk;
            logic [W-1:0] y;
            rst_n = 1'b0;
            valid = 1'b0;
            enc   = 1'b0;
            d     = 8'h00;
            k     = 8'h00;
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            for (int n = 0; n < NPAIR; n++) begin
                x  = W'($urandom);
                kk = W'($urandom);
                y  = W'(ref_cipher(32'(x), 32'(kk), NB, RN, 1'b1));
                send(x, kk, 1'b1, y);
                send(y, kk, 1'b0, x);
            end
            repeat (2) @(negedge clk);
            done = 1'b1;
        end

        // Compare process: every strobe against the model, data held otherwise.
        always @(negedge clk) begin
            if (rst_n) begin
                if (ovalid) begin
                    vchk($sformatf("rt%0d_pending", gi), 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        vchk($sformatf("rt%0d_data", gi), 32'(odata), 32'(exp_q[0]));
                        vchk($sformatf("rt%0d_latency", gi), 32'(cyc), 32'(exp_c[0]));
                        void'(exp_q.pop_front());
                        void'(exp_c.pop_front());
                    end
                end else begin
                    vchk($sformatf("rt%0d_hold", gi), 32'(odata), 32'(last_data));
                end
            end
            last_data <= odata;
        end
    end

    // ---------------- directed sequence and summary ----------------
    initial begin
        int guard;
        v_rst_n = 1'b0;
        v_valid = 1'b0;
        v_enc   = 1'b0;
        v_d     = 8'h00;
        v_k     = 8'h00;

        vchk("model_enc", ref_cipher(32'h6F6B, 32'hA73B, 2, 2, 1'b1), 32'h560F);
        vchk("model_dec", ref_cipher(32'h560F, 32'hA73B, 2, 2, 1'b0), 32'h6F6B);
        vchk("model_nb1", ref_cipher(32'h12, 32'h34, 1, 1, 1'b1), 32'h4C);

        // Reset held with random activity on the inputs.
        for (int i = 0; i < 4; i++) begin
            v_valid = 1'($urandom);
            v_enc   = 1'($urandom);
            v_d     = 8'($urandom);
            v_k     = 8'($urandom);
            @(negedge clk);
            vchk("rst_data", 32'(v_odata), 32'h0);
            vchk("rst_valid", 32'(v_ovalid), 32'h0);
            vchk("rst_ready", 32'(v_ready), 32'h1);
            vchk("rst_busy", 32'(v_busy), 32'h0);
        end
        v_valid = 1'b0;
        v_rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vchk("idle_busy", 32'(v_busy), 32'h0);
            vchk("idle_valid", 32'(v_ovalid), 32'h0);
        end

        v_block(16'h6F6B, 16'hA73B, 1'b1, 1'b0, 16'h560F, "enc");
        v_block(16'h560F, 16'hA73B, 1'b0, 1'b0, 16'h6F6B, "dec");
        v_block(16'h6F6B, 16'hA73B, 1'b1, 1'b1, 16'h560F, "gap");

        // Reset during RUN round 1 of an encode block.
        v_valid = 1'b1;
        v_enc   = 1'b1;
        v_d     = 8'h12;
        v_k     = 8'h34;
        @(negedge clk);
        v_d     = 8'h56;
        v_k     = 8'h78;
        @(negedge clk);
        v_valid = 1'b0;
        @(negedge clk);
        v_rst_n = 1'b0;
        #1;
        vchk("mid_rst_data", 32'(v_odata), 32'h0);
        vchk("mid_rst_valid", 32'(v_ovalid), 32'h0);
        vchk("mid_rst_ready", 32'(v_ready), 32'h1);
        vchk("mid_rst_busy", 32'(v_busy), 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vchk("mid_rst_hold_valid", 32'(v_ovalid), 32'h0);
        end
        v_rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vchk("post_rst_valid", 32'(v_ovalid), 32'h0);
            vchk("post_rst_busy", 32'(v_busy), 32'h0);
        end
        v_block(16'h560F, 16'hA73B, 1'b0, 1'b0, 16'h6F6B, "after_rst");

        guard = 0;
        while (!(g_rt[0].done && g_rt[1].done && g_rt[2].done) && guard < 60000) begin
            @(negedge clk);
            guard++;
        end
        vchk("rt_complete", 32'(g_rt[0].done && g_rt[1].done && g_rt[2].done), 32'h1);
        vchk("rt0_drain", 32'(g_rt[0].exp_q.size()), 32'h0);
        vchk("rt1_drain", 32'(g_rt[1].exp_q.size()), 32'h0);
        vchk("rt2_drain", 32'(g_rt[2].exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
